dual_port_ram_ex: RTL

DUAL_PORT_RAM_EX -- requirements
Module: dual_port_ram_ex

---
 rtl/dual_port_ram_ex_pkg.sv | 15 +
 rtl/ram_port_pipe.sv | 57 +++++
 rtl/dual_port_ram_ex.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dual_port_ram_ex_pkg.sv
// Shared types for the dual-port RAM: FSM state and read-during-write modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dual_port_ram_ex_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Same-port read-during-write behaviour selected by RD_MODE.
  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

endpackage

// File: rtl/ram_port_pipe.sv
// Per-port read result pipeline: captures read data and issues a valid pulse.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from req_vld to valid.
// Backpressure: none; one result per cycle, dout holds its value between pulses.
// Ports: clk/rst_n, req_vld + rd_dat (request and data sampled at the edge),
//        dout/valid (registered result and its one-cycle qualifier).
module ram_port_pipe
  import dual_port_ram_ex_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OUT_REG   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_vld,
  input  logic [DATA_BITS-1:0] rd_dat,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid
);

  logic                 s1_vld;
  logic [DATA_BITS-1:0] s1_dat;

  // Data register only loads on a request so dout holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= req_vld;
      if (req_vld) s1_dat <= rd_dat;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                 s2_vld;
      logic [DATA_BITS-1:0] s2_dat;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld <= 1'b0;
          s2_dat <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) s2_dat <= s1_dat;
        end
      end

      assign dout  = s2_dat;
      assign valid = s2_vld;
    end else begin : g_no_out_reg
      assign dout  = s1_dat;
      assign valid = s1_vld;
    end
  endgenerate

endmodule

// File: rtl/dual_port_ram_ex.sv
// True dual-port RAM with a self-clearing INIT sequence and same-address write detection.
// Latency: read data 1 cycle after request (2 with OUT_REG=1); writes land at the edge.
// Backpressure: none; accesses during init_busy (and on a clear_req cycle) are dropped.
// Ports: clk/rst_n, clear_req/init_busy (memory clear control), per-port en/we/addr/din
//        in, dout/valid out, collision (one-cycle pulse after a same-address dual write).
module dual_port_ram_ex
  import dual_port_ram_ex_pkg::*;
#(
  parameter int ADDR_SIZE  = 6,
  parameter int DATA_BITS  = 8,
  parameter int NO_OF_ADDR = 64,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_req,
  output logic                 init_busy,
  input  logic                 en_a,
  input  logic                 en_b,
  input  logic                 we_a,
  input  logic                 we_b,
  input  logic [ADDR_SIZE-1:0] addr_a,
  input  logic [ADDR_SIZE-1:0] addr_b,
  input  logic [DATA_BITS-1:0] din_a,
  input  logic [DATA_BITS-1:0] din_b,
  output logic [DATA_BITS-1:0] dout_a,
  output logic [DATA_BITS-1:0] dout_b,
  output logic                 valid_a,
  output logic                 valid_b,
  output logic                 collision
);

  localparam logic [ADDR_SIZE:0]   ADDR_LIMIT = (ADDR_SIZE + 1)'(NO_OF_ADDR);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR  = ADDR_SIZE'(NO_OF_ADDR - 1);

  state_t               state;
  logic [ADDR_SIZE-1:0] cnt;
  logic [DATA_BITS-1:0] mem [NO_OF_ADDR];

  logic                 acc_ok;
  logic                 in_range_a, in_range_b;
  logic                 wr_a, wr_b;
  logic                 req_a, req_b;
  logic                 coll_now;
  logic [DATA_BITS-1:0] rd_dat_a, rd_dat_b;

  // A clear request wins over any access presented in the same cycle.
  assign acc_ok     = (state == READY) && !clear_req;
  assign in_range_a = {1'b0, addr_a} < ADDR_LIMIT;
  assign in_range_b = {1'b0, addr_b} < ADDR_LIMIT;

  // Port A owns the word when both ports write the same address.
  assign wr_a     = acc_ok && en_a && we_a && in_range_a;
  assign wr_b     = acc_ok && en_b && we_b && in_range_b && !(wr_a && (addr_a == addr_b));
  assign coll_now = acc_ok && en_a && we_a && en_b && we_b && (addr_a == addr_b);

  // In write-first mode a write also returns its own data as a read result.
  assign req_a = acc_ok && en_a && (!we_a || (RD_MODE == WR_FIRST));
  assign req_b = acc_ok && en_b && (!we_b || (RD_MODE == WR_FIRST));

  // Array read happens before the edge, so cross-port reads see the old word.
  always_comb begin
    rd_dat_a = '0;
    if (in_range_a) rd_dat_a = we_a ? din_a : mem[addr_a];
  end

  always_comb begin
    rd_dat_b = '0;
    if (in_range_b) rd_dat_b = we_b ? din_b : mem[addr_b];
  end

  // The array itself has no reset; only the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else begin
      if (wr_b) mem[addr_b] <= din_b;
      if (wr_a) mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      collision <= 1'b0;
    end else begin
      collision <= coll_now;
      case (state)
        INIT: begin
          if (clear_req) begin
            cnt <= '0;
          end else if (cnt == LAST_ADDR) begin
            state <= READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (clear_req) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign init_busy = (state == INIT);

  ram_port_pipe #(.DATA_BITS(DATA_BITS), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_a),
    .rd_dat  (rd_dat_a),
    .dout    (dout_a),
    .valid   (valid_a)
  );

  ram_port_pipe #(.DATA_BITS(DATA_BITS), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_b),
    .rd_dat  (rd_dat_b),
    .dout    (dout_b),
    .valid   (valid_b)
  );

endmodule
